// File: rtl/blink_rate_decoder.sv
// blink_rate_decoder
// Measures the half-period of an incoming blink waveform and decodes which of
// the four blink-generator rates is present. The result uses the generator's
// 2-bit select code {s1,s2}.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sig          asynchronous blink waveform under test
//   rate[1:0]    decoded rate code; holds its last value while not valid
//   valid        high while locked on a rate
//   lost         one-cycle pulse when no edge arrives within TIMEOUT cycles
//   half_period  (only with BLINK_DEC_PERIOD_OUT_EN) last classified interval
//
// Optional feature macro: BLINK_DEC_PERIOD_OUT_EN adds the half_period output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for the first edge; intervals are not yet meaningful
// MEASURE | collecting consecutive matching intervals toward a lock
// LOCKED  | rate is valid; any non-matching interval drops back to MEASURE

module blink_rate_decoder #(
    parameter int VAL25    = 500,
    parameter int VAL10    = 1250,
    parameter int VAL5     = 2500,
    parameter int VAL1     = 12500,
    parameter int TOL      = 8,
    parameter int LOCK_CNT = 2,
    parameter int TIMEOUT  = 25000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    output logic [1:0]       rate,
    output logic             valid,
    output logic             lost
`ifdef BLINK_DEC_PERIOD_OUT_EN
    ,
    output logic [CNT_W-1:0] half_period
`endif
);

    localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_CNT);
    localparam logic [MW-1:0]    ONE_M   = MW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [CNT_W:0] LO0 = (CNT_W+1)'(VAL25 - TOL);
    localparam logic [CNT_W:0] HI0 = (CNT_W+1)'(VAL25 + TOL);
    localparam logic [CNT_W:0] LO1 = (CNT_W+1)'(VAL10 - TOL);
    localparam logic [CNT_W:0] HI1 = (CNT_W+1)'(VAL10 + TOL);
    localparam logic [CNT_W:0] LO2 = (CNT_W+1)'(VAL5 - TOL);
    localparam logic [CNT_W:0] HI2 = (CNT_W+1)'(VAL5 + TOL);
    localparam logic [CNT_W:0] LO3 = (CNT_W+1)'(VAL1 - TOL);
    localparam logic [CNT_W:0] HI3 = (CNT_W+1)'(VAL1 + TOL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state;
    logic             sync1, sync2, sync3;
    logic             sig_edge;
    logic [CNT_W-1:0] hp_cnt;
    logic [CNT_W:0]   interval;
    logic             cls_ok;
    logic [1:0]       cls_code;
    logic [1:0]       cand;
    logic [MW-1:0]    match;
    logic [1:0]       nxt_cand;
    logic [MW-1:0]    nxt_match;
    logic             timeout;

    // sync1/sync2 resynchronize sig; sync3 delays it one more cycle so both
    // transition directions show up as a single-cycle edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign sig_edge = sync2 ^ sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_cnt <= '0;
        end else if (sig_edge) begin
            hp_cnt <= '0;
        end else if (hp_cnt != CNT_MAX) begin
            hp_cnt <= hp_cnt + CNT_W'(1);
        end
    end

    // Counter holds cycles since the previous edge minus one.
    assign interval = {1'b0, hp_cnt} + (CNT_W+1)'(1);
    assign timeout  = (hp_cnt == TO_LAST) && !sig_edge;

    // Windows checked in code order; the first hit wins if windows overlap.
    always_comb begin
        cls_ok   = 1'b1;
        cls_code = 2'b00;
        if (interval >= LO0 && interval <= HI0) begin
            cls_code = 2'b00;
        end else if (interval >= LO1 && interval <= HI1) begin
            cls_code = 2'b01;
        end else if (interval >= LO2 && interval <= HI2) begin
            cls_code = 2'b10;
        end else if (interval >= LO3 && interval <= HI3) begin
            cls_code = 2'b11;
        end else begin
            cls_ok = 1'b0;
        end
    end

    // Candidate tracking used while measuring.
    always_comb begin
        nxt_cand  = cand;
        nxt_match = '0;
        if (cls_ok) begin
            if (cls_code == cand) begin
                nxt_match = match + ONE_M;
            end else begin
                nxt_cand  = cls_code;
                nxt_match = ONE_M;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= 2'b00;
            match <= '0;
            rate  <= 2'b00;
            valid <= 1'b0;
            lost  <= 1'b0;
`ifdef BLINK_DEC_PERIOD_OUT_EN
            half_period <= '0;
`endif
        end else begin
            lost <= 1'b0;
            case (state)
                IDLE: begin
                    if (sig_edge) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (sig_edge) begin
`ifdef BLINK_DEC_PERIOD_OUT_EN
                        half_period <= interval[CNT_W-1:0];
`endif
                        cand  <= nxt_cand;
                        match <= nxt_match;
                        if (nxt_match == LOCK_M) begin
                            state <= LOCKED;
                            rate  <= nxt_cand;
                            valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        lost  <= 1'b1;
                        match <= '0;
                    end
                end
                LOCKED: begin
                    if (sig_edge) begin
`ifdef BLINK_DEC_PERIOD_OUT_EN
                        half_period <= interval[CNT_W-1:0];
`endif
                        if (!(cls_ok && cls_code == rate)) begin
                            state <= MEASURE;
                            valid <= 1'b0;
                            cand  <= cls_code;
                            match <= cls_ok ? ONE_M : '0;
                        end
                    end else if (timeout) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        lost  <= 1'b1;
                        match <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    match <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_rate_decoder.sv
module tb_blink_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig = 1'b0;
    logic [1:0] rate;
    logic       valid;
    logic       lost;
`ifdef BLINK_DEC_PERIOD_OUT_EN
    logic [15:0] half_period;
`endif

    blink_rate_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sig),
        .rate  (rate),
        .valid (valid),
        .lost  (lost)
`ifdef BLINK_DEC_PERIOD_OUT_EN
        ,
        .half_period (half_period)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] obs;   // {valid, rate, lost}
        int         at;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input string name, input logic v, input logic [1:0] r,
                             input logic l, input int at);
        exp_t e;
        e.obs  = {v, r, l};
        e.at   = at;
        e.name = name;
        q.push_back(e);
    endtask

    // Toggle sig n clock cycles after the previous call; k is the cycle count
    // right after the posedge that precedes the transition.
    task automatic gap(input int n, output int k);
        repeat (n) @(posedge clk);
        #1 sig = ~sig;
        k = cyc;
    endtask

    // Monitor: any change on the outputs must match the next expected event.
    logic [3:0] mon_prev = 4'b0000;
    logic [3:0] mon_cur;
    exp_t       mon_e;
    always @(negedge clk) begin
        mon_cur = {valid, rate, lost};
        if (mon_cur !== mon_prev) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_change: got %b, expected no change from %b (cycle %0d)",
                         mon_cur, mon_prev, cyc);
            end else begin
                mon_e = q.pop_front();
                check({mon_e.name, "_out"}, int'(mon_cur), int'(mon_e.obs));
                check({mon_e.name, "_cycle"}, cyc, mon_e.at);
            end
            mon_prev = mon_cur;
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        sig   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(valid), 0);
        check("reset_rate", int'(rate), 0);
        check("reset_lost", int'(lost), 0);
        rst_n = 1'b1;

        // Lock at 2'b00: edges every 500 cycles, valid one cycle after 3rd edge.
        gap(20, k);
        gap(500, k);
        gap(500, k);
        expect_ev("lock00", 1'b1, 2'b00, 1'b0, k + 3);

        // Reset mid-lock clears outputs immediately.
        repeat (100) @(posedge clk);
        #1;
        expect_ev("rst_drop", 1'b0, 2'b00, 1'b0, cyc);
        rst_n = 1'b0;
        sig   = 1'b0;
        #1;
        check("midrst_valid", int'(valid), 0);
        check("midrst_rate", int'(rate), 0);
        check("midrst_lost", int'(lost), 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;

        // Relock needs three edges again.
        gap(50, k);
        gap(500, k);
        gap(500, k);
        expect_ev("relock00", 1'b1, 2'b00, 1'b0, k + 3);

        // Edge exactly at hp_cnt = TIMEOUT-1: interval 25000 is UNKNOWN, no lost.
        gap(25000, k);
        expect_ev("edge_at_timeout", 1'b0, 2'b00, 1'b0, k + 3);

        // 1258 is in the 2'b01 window, 1259 is not and clears match.
        gap(1258, k);
        gap(1259, k);
        gap(1258, k);
        gap(1258, k);
        expect_ev("lock01", 1'b1, 2'b01, 1'b0, k + 3);

        // Switch to the slowest rate.
        gap(12500, k);
        expect_ev("leave01", 1'b0, 2'b01, 1'b0, k + 3);
        gap(12500, k);
        expect_ev("lock11", 1'b1, 2'b11, 1'b0, k + 3);
`ifdef BLINK_DEC_PERIOD_OUT_EN
        repeat (5) @(posedge clk);
        #1;
        check("half_period", int'(half_period), 12500);
`endif

        // Hold sig: lost pulses 25000 cycles after the last edge, rate held.
        expect_ev("lost_pulse", 1'b0, 2'b11, 1'b1, k + 3 + 25000);
        expect_ev("lost_end", 1'b0, 2'b11, 1'b0, k + 3 + 25001);
        repeat (25100) @(posedge clk);

        // Back in IDLE with constant sig: nothing else may happen.
        repeat (300) @(posedge clk);
        #1;
        check("pending_events", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
